// File: rtl/sound_glu_arb.sv
// Sound GLU host register file with DOC slot timing and RAM/DOC bus arbiter.
// Host data-port operations are snapshotted and issued only in slots the DOC does not own.
module sound_glu_arb #(
    parameter int ADDR_W  = 16,
    parameter int DOC_DIV = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              select,
    input  logic              wr,
    input  logic [1:0]        host_addr,
    input  logic [7:0]        host_data_in,
    output logic [7:0]        host_data_out,
    input  logic [7:0]        sound_data_in,
    output logic              ram_access,
    output logic [ADDR_W-1:0] sound_addr,
    output logic [7:0]        sound_data_out,
    output logic              ram_wr,
    output logic              doc_wr,
    output logic              doc_enable,
    output logic [3:0]        volume,
    output logic              busy
);

    localparam int CNT_W = (DOC_DIV > 1) ? $clog2(DOC_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DOC_DIV - 1);
    localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(DOC_DIV - 3);

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_ALO  = 2'd2;
    localparam logic [1:0] REG_AHI  = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              ram;
        logic              wr;
        logic [7:0]        data;
    } op_t;

    logic [CNT_W-1:0]  cnt;
    logic              sel_d;
    logic [1:0]        ctrl_mode;   // ctrl[6] = RAM target, ctrl[5] = auto-increment
    logic [3:0]        vol;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        data_latch;
    op_t               op;
    logic              pending;
    logic              capture;
    logic              addr_hi;

    logic acc;
    logic acc_wr;
    logic queue;
    logic issue;

    generate
        if (ADDR_W == 17) begin : g_a17
            assign addr_hi = addr[ADDR_W-1];
        end else begin : g_a16
            assign addr_hi = 1'b0;
        end
    endgenerate

    assign acc    = select & ~sel_d;
    assign acc_wr = acc & wr;
    assign busy   = pending | capture;
    assign queue  = acc & (host_addr == REG_DATA) & ~busy;
    // Slots DOC_DIV-1 and 0 belong to the DOC; DOC_DIV-2 is left clear so a
    // read's capture cycle never lands in a DOC fetch.
    assign issue  = pending & (cnt != '0) & (cnt <= ISSUE_LAST);

    always_comb begin
        addr_nxt = addr;
        if (acc_wr && host_addr == REG_CTRL && ADDR_W == 17)
            addr_nxt[ADDR_W-1] = host_data_in[4];
        if (acc_wr && host_addr == REG_ALO)
            addr_nxt[7:0] = host_data_in;
        if (acc_wr && host_addr == REG_AHI)
            addr_nxt[15:8] = host_data_in;
        if (queue && ctrl_mode[0])
            addr_nxt = addr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            sel_d      <= 1'b0;
            ctrl_mode  <= '0;
            vol        <= '0;
            addr       <= '0;
            data_latch <= '0;
            op         <= '0;
            pending    <= 1'b0;
            capture    <= 1'b0;
        end else begin
            cnt   <= (cnt == SLOT_LAST) ? '0 : cnt + CNT_W'(1);
            sel_d <= select;
            addr  <= addr_nxt;
            if (acc_wr && host_addr == REG_CTRL) begin
                ctrl_mode <= host_data_in[6:5];
                vol       <= host_data_in[3:0];
            end
            if (queue) begin
                op.addr <= addr;
                op.ram  <= ctrl_mode[1];
                op.wr   <= wr;
                op.data <= host_data_in;
                pending <= 1'b1;
            end else if (issue) begin
                pending <= 1'b0;
            end
            capture <= issue & ~op.wr;
            if (capture)
                data_latch <= sound_data_in;
        end
    end

    always_comb begin
        host_data_out = 8'h00;
        case (host_addr)
            REG_CTRL: host_data_out = {busy, ctrl_mode, addr_hi, vol};
            REG_DATA: host_data_out = data_latch;
            REG_ALO:  host_data_out = addr[7:0];
            REG_AHI:  host_data_out = addr[15:8];
            default:  host_data_out = 8'h00;
        endcase
    end

    assign ram_access     = ctrl_mode[1];
    assign volume         = vol;
    assign doc_enable     = (cnt == SLOT_LAST);
    assign sound_addr     = issue ? op.addr : addr;
    assign sound_data_out = issue ? op.data : 8'h00;
    assign ram_wr         = issue & op.wr & op.ram;
    assign doc_wr         = issue & op.wr & ~op.ram;

endmodule

// File: tb/tb_sound_glu_arb.sv
// Directed bench for sound_glu_arb: a 16-bit and a 17-bit instance share host stimulus,
// with a registered-read sound RAM / DOC register model behind the 16-bit one.
module tb_sound_glu_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        select = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  host_addr = 2'd0;
    logic [7:0]  host_data_in = 8'h00;
    logic [7:0]  sound_data_in = 8'h00;

    logic [7:0]  hdo16, sdo16, hdo17, sdo17;
    logic [15:0] sa16;
    logic [16:0] sa17;
    logic        ra16, rw16, dw16, de16, busy16;
    logic        ra17, rw17, dw17, de17, busy17;
    logic [3:0]  vol16, vol17;

    logic [7:0]  mem  [0:65535];
    logic [7:0]  docr [0:255];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_ram    = 0;
    int n_doc    = 0;
    int bad_slot = 0;
    int ram_slot = -1;
    logic [15:0] ram_a = '0, doc_a = '0;
    logic [7:0]  ram_d = '0, doc_d = '0;

    sound_glu_arb #(.ADDR_W(16), .DOC_DIV(8)) dut16 (
        .clk(clk), .reset(reset), .select(select), .wr(wr), .host_addr(host_addr),
        .host_data_in(host_data_in), .host_data_out(hdo16), .sound_data_in(sound_data_in),
        .ram_access(ra16), .sound_addr(sa16), .sound_data_out(sdo16), .ram_wr(rw16),
        .doc_wr(dw16), .doc_enable(de16), .volume(vol16), .busy(busy16)
    );

    sound_glu_arb #(.ADDR_W(17), .DOC_DIV(8)) dut17 (
        .clk(clk), .reset(reset), .select(select), .wr(wr), .host_addr(host_addr),
        .host_data_in(host_data_in), .host_data_out(hdo17), .sound_data_in(sound_data_in),
        .ram_access(ra17), .sound_addr(sa17), .sound_data_out(sdo17), .ram_wr(rw17),
        .doc_wr(dw17), .doc_enable(de17), .volume(vol17), .busy(busy17)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data for an address issued in cycle k is presented in cycle k+1.
    always @(posedge clk) begin
        if (rw16) mem[sa16] <= sdo16;
        if (dw16) docr[sa16[7:0]] <= sdo16;
        sound_data_in <= ra16 ? mem[sa16] : docr[sa16[7:0]];
    end

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (rw16) begin
                n_ram++; ram_a = sa16; ram_d = sdo16; ram_slot = cyc % 8;
            end
            if (dw16) begin
                n_doc++; doc_a = sa16; doc_d = sdo16;
            end
            if ((rw16 || dw16) && (cyc % 8 == 0 || cyc % 8 >= 6)) bad_slot++;
        end
    end

    task automatic host_access(input logic [1:0] a, input logic w, input logic [7:0] d,
                               output logic [7:0] q);
        select = 1'b1; host_addr = a; wr = w; host_data_in = d;
        #1 q = hdo16;
        @(negedge clk);
        select = 1'b0; wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic align(input int s);
        @(negedge clk);
        while (cyc % 8 != s) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0; host_addr = 2'd0;
        #1;
        n_assert++;
        if ({hdo16, ra16, sa16, sdo16, rw16, dw16, de16, vol16, busy16} !== 41'd0) begin
            n_fail++; $display("FAIL reset_outputs16: got %h expected 0",
                {hdo16, ra16, sa16, sdo16, rw16, dw16, de16, vol16, busy16});
        end
        n_assert++;
        if ({hdo17, ra17, sa17, sdo17, rw17, dw17, de17, vol17, busy17} !== 42'd0) begin
            n_fail++; $display("FAIL reset_outputs17: got %h expected 0",
                {hdo17, ra17, sa17, sdo17, rw17, dw17, de17, vol17, busy17});
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 64; i++) begin
            n_assert++;
            if (de16 !== (i % 8 == 7)) begin
                n_fail++; $display("FAIL idle_doc_enable cycle %0d: got %b expected %b", i, de16, (i % 8 == 7));
            end
            @(negedge clk); #1;
        end
        n_assert++;
        if (n_ram + n_doc !== 0) begin
            n_fail++; $display("FAIL idle_strobes: got %0d expected 0", n_ram + n_doc);
        end
    endtask

    task automatic test_ram_write;
        logic [7:0] q;
        int r0;
        @(negedge clk);
        host_access(2'd0, 1'b1, 8'h60, q);
        host_access(2'd2, 1'b1, 8'h34, q);
        host_access(2'd3, 1'b1, 8'h12, q);
        r0 = n_ram;
        align(6);
        host_access(2'd1, 1'b1, 8'hAB, q);
        host_addr = 2'd0; #1;
        n_assert++;
        if (hdo16 !== 8'hE0) begin
            n_fail++; $display("FAIL wr_busy_visible: got %h expected e0", hdo16);
        end
        repeat (8) @(negedge clk);
        #1;
        n_assert++;
        if (n_ram - r0 !== 1) begin
            n_fail++; $display("FAIL wr_strobe_count: got %0d expected 1", n_ram - r0);
        end
        n_assert++;
        if (ram_slot !== 1) begin
            n_fail++; $display("FAIL wr_issue_slot: got %0d expected 1", ram_slot);
        end
        n_assert++;
        if ({ram_a, ram_d} !== {16'h1234, 8'hAB}) begin
            n_fail++; $display("FAIL wr_addr_data: got %h/%h expected 1234/ab", ram_a, ram_d);
        end
        n_assert++;
        if (hdo16 !== 8'h60 || busy16 !== 1'b0) begin
            n_fail++; $display("FAIL wr_busy_drop: got %h/%b expected 60/0", hdo16, busy16);
        end
        host_addr = 2'd2; #1;
        n_assert++;
        if (hdo16 !== 8'h35) begin
            n_fail++; $display("FAIL wr_addr_lo: got %h expected 35", hdo16);
        end
        host_addr = 2'd3; #1;
        n_assert++;
        if (hdo16 !== 8'h12) begin
            n_fail++; $display("FAIL wr_addr_hi: got %h expected 12", hdo16);
        end
    endtask

    task automatic test_read_autoinc;
        logic [7:0] q;
        mem[16'h1235] = 8'h5C;
        @(negedge clk);
        // No data read since reset, so the latch still holds its reset value.
        host_access(2'd1, 1'b0, 8'h00, q);
        n_assert++;
        if (q !== 8'h00) begin
            n_fail++; $display("FAIL rd_first_stale: got %h expected 00", q);
        end
        repeat (10) @(negedge clk);
        host_access(2'd1, 1'b0, 8'h00, q);
        n_assert++;
        if (q !== 8'h5C) begin
            n_fail++; $display("FAIL rd_second_data: got %h expected 5c", q);
        end
        repeat (10) @(negedge clk);
        host_addr = 2'd1; #1;
        n_assert++;
        if (hdo16 !== 8'h00) begin
            n_fail++; $display("FAIL rd_latch_1236: got %h expected 00", hdo16);
        end
        host_addr = 2'd2; #1;
        n_assert++;
        if (hdo16 !== 8'h37) begin
            n_fail++; $display("FAIL rd_addr_lo: got %h expected 37", hdo16);
        end
        host_addr = 2'd3; #1;
        n_assert++;
        if (hdo16 !== 8'h12) begin
            n_fail++; $display("FAIL rd_addr_hi: got %h expected 12", hdo16);
        end
    endtask

    task automatic test_addr_wrap;
        logic [7:0] q;
        @(negedge clk);
        host_access(2'd0, 1'b1, 8'h60, q);
        host_access(2'd2, 1'b1, 8'hFF, q);
        host_access(2'd3, 1'b1, 8'hFF, q);
        host_access(2'd1, 1'b1, 8'h11, q);
        repeat (10) @(negedge clk);
        host_addr = 2'd2; #1;
        n_assert++;
        if ({hdo16, hdo17} !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addr_lo: got %h/%h expected 00/00", hdo16, hdo17);
        end
        host_addr = 2'd3; #1;
        n_assert++;
        if ({hdo16, hdo17} !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addr_hi: got %h/%h expected 00/00", hdo16, hdo17);
        end
        host_addr = 2'd0; #1;
        n_assert++;
        if (hdo16 !== 8'h60) begin
            n_fail++; $display("FAIL wrap_ctrl16: got %h expected 60", hdo16);
        end
        n_assert++;
        if (hdo17 !== 8'h70) begin
            n_fail++; $display("FAIL wrap_ctrl17_bit4: got %h expected 70", hdo17);
        end
        n_assert++;
        if (sa16 !== 16'h0000 || sa17 !== 17'h10000) begin
            n_fail++; $display("FAIL wrap_sound_addr: got %h/%h expected 0000/10000", sa16, sa17);
        end
    endtask

    task automatic test_doc_write;
        logic [7:0] q;
        int r0, d0;
        @(negedge clk);
        host_access(2'd0, 1'b1, 8'h05, q);
        host_access(2'd2, 1'b1, 8'hE1, q);
        host_access(2'd3, 1'b1, 8'h00, q);
        r0 = n_ram; d0 = n_doc;
        host_access(2'd1, 1'b1, 8'h3E, q);
        repeat (10) @(negedge clk);
        #1;
        n_assert++;
        if (n_doc - d0 !== 1 || n_ram - r0 !== 0) begin
            n_fail++; $display("FAIL doc_strobes: got doc %0d ram %0d expected 1/0", n_doc - d0, n_ram - r0);
        end
        n_assert++;
        if ({doc_a[7:0], doc_d} !== 16'hE13E) begin
            n_fail++; $display("FAIL doc_addr_data: got %h/%h expected e1/3e", doc_a[7:0], doc_d);
        end
        n_assert++;
        if (vol16 !== 4'h5 || ra16 !== 1'b0) begin
            n_fail++; $display("FAIL doc_vol_target: got %h/%b expected 5/0", vol16, ra16);
        end
        host_addr = 2'd2; #1;
        n_assert++;
        if (hdo16 !== 8'hE1) begin
            n_fail++; $display("FAIL doc_addr_noinc: got %h expected e1", hdo16);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] q;
        int r0;
        @(negedge clk);
        host_access(2'd0, 1'b1, 8'h60, q);
        host_access(2'd2, 1'b1, 8'h00, q);
        host_access(2'd3, 1'b1, 8'h20, q);
        r0 = n_ram;
        align(6);
        host_access(2'd1, 1'b1, 8'h77, q);
        host_access(2'd1, 1'b1, 8'h88, q);
        repeat (10) @(negedge clk);
        #1;
        n_assert++;
        if (n_ram - r0 !== 1) begin
            n_fail++; $display("FAIL b2b_strobe_count: got %0d expected 1", n_ram - r0);
        end
        n_assert++;
        if ({ram_a, ram_d} !== {16'h2000, 8'h77} || ram_slot !== 1) begin
            n_fail++; $display("FAIL b2b_addr_data_slot: got %h/%h/%0d expected 2000/77/1", ram_a, ram_d, ram_slot);
        end
        host_addr = 2'd2; #1;
        n_assert++;
        if (hdo16 !== 8'h01) begin
            n_fail++; $display("FAIL b2b_single_inc: got %h expected 01", hdo16);
        end
    endtask

    task automatic test_reset_midop;
        logic [7:0] q;
        int r0;
        r0 = n_ram;
        align(6);
        host_access(2'd1, 1'b1, 8'h99, q);
        #1;
        n_assert++;
        if (busy16 !== 1'b1) begin
            n_fail++; $display("FAIL midop_busy_before: got %b expected 1", busy16);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; host_addr = 2'd1;
        #1;
        n_assert++;
        if ({hdo16, ra16, sa16, sdo16, rw16, dw16, de16, vol16, busy16} !== 41'd0) begin
            n_fail++; $display("FAIL midop_outputs: got %h expected 0",
                {hdo16, ra16, sa16, sdo16, rw16, dw16, de16, vol16, busy16});
        end
        repeat (10) @(negedge clk);
        n_assert++;
        if (n_ram - r0 !== 0) begin
            n_fail++; $display("FAIL midop_no_strobe: got %0d expected 0", n_ram - r0);
        end
        n_assert++;
        if (bad_slot !== 0) begin
            n_fail++; $display("FAIL strobe_in_doc_slot: got %0d expected 0", bad_slot);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) docr[i] = 8'h00;
        test_reset;
        test_idle;
        test_ram_write;
        test_read_autoinc;
        test_addr_wrap;
        test_doc_write;
        test_back_to_back;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
